// File: rtl/addsub_pkg.sv
// Shared definitions for the adder/subtractor datapath and its result buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package addsub_pkg;

  // Occupancy of the two-entry result buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  // Bit positions inside the 4-bit {N,Z,C,V} flag word.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Operation select, shared with the adder/subtractor top.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_flag_gen.sv
// Status flag generator: N/Z/C/V from operands, op select, result and carry.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no state.
// Ports: a, b (operands), sel (OP_ADD/OP_SUB), s (result), cout (carry/borrow)
//        -> flags {N,Z,C,V}.
module addsub_flag_gen
  import addsub_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sel,
  input  logic [N-1:0] s,
  input  logic         cout,
  output logic [3:0]   flags
);

  logic same_sign;

  // Subtracting B flips its effective sign, so overflow in A-B needs
  // operands of opposite sign; in A+B it needs operands of the same sign.
  // Either way the result sign must differ from A.
  assign same_sign = (a[N-1] == b[N-1]);

  always_comb begin
    flags         = '0;
    flags[FLAG_N] = s[N-1];
    flags[FLAG_Z] = (s == '0);
    flags[FLAG_C] = cout;
    flags[FLAG_V] = ((sel == OP_SUB) ? !same_sign : same_sign) && (s[N-1] != a[N-1]);
  end

endmodule

// File: rtl/addsub_result_buffer.sv
// Result buffer: captures {S,cout} plus flags into a 2-entry in-order queue.
// Latency: push into an empty buffer is visible at the output the next cycle.
// Backpressure: valid/ready; in_ready depends on occupancy only (low when full).
// Ports: clk, rst_n; in_valid/in_ready with in_a, in_b, in_sel, in_s, in_cout;
//        out_valid/out_ready with out_s, out_flags; op_count (accepted pushes).
module addsub_result_buffer
  import addsub_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_a,
  input  logic [N-1:0]  in_b,
  input  logic          in_sel,
  input  logic [N-1:0]  in_s,
  input  logic          in_cout,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_s,
  output logic [3:0]    out_flags,
  output logic [CW-1:0] op_count
);

  buf_state_t   state, state_nxt;
  logic [3:0]   in_flags;
  logic         push, pop;
  logic         load_head_in, load_head_tail, load_tail;
  logic [N-1:0] head_s, tail_s;
  logic [3:0]   head_f, tail_f;

  addsub_flag_gen #(.N(N)) u_flag_gen (
    .a     (in_a),
    .b     (in_b),
    .sel   (in_sel),
    .s     (in_s),
    .cout  (in_cout),
    .flags (in_flags)
  );

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // The head register always holds the oldest entry; the tail is only
  // occupied in FULL.
  always_comb begin
    state_nxt      = state;
    load_head_in   = 1'b0;
    load_head_tail = 1'b0;
    load_tail      = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          state_nxt    = ONE;
          load_head_in = 1'b1;
        end
      end
      ONE: begin
        case ({push, pop})
          2'b10: begin
            state_nxt = FULL;
            load_tail = 1'b1;
          end
          2'b01:   state_nxt = EMPTY;
          // Head leaves and the new entry replaces it in the same cycle.
          2'b11:   load_head_in = 1'b1;
          default: state_nxt = ONE;
        endcase
      end
      FULL: begin
        if (pop) begin
          state_nxt      = ONE;
          load_head_tail = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_s   <= '0;
      head_f   <= '0;
      tail_s   <= '0;
      tail_f   <= '0;
      op_count <= '0;
    end else begin
      if (load_head_in) begin
        head_s <= in_s;
        head_f <= in_flags;
      end else if (load_head_tail) begin
        head_s <= tail_s;
        head_f <= tail_f;
      end
      if (load_tail) begin
        tail_s <= in_s;
        tail_f <= in_flags;
      end
      if (push) op_count <= op_count + CW'(1);
    end
  end

  assign out_s     = head_s;
  assign out_flags = head_f;

endmodule

// File: tb/tb_addsub_result_buffer.sv
module tb_addsub_result_buffer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_a = '0;
  logic [3:0] in_b = '0;
  logic       in_sel = 1'b0;
  logic [3:0] in_s = '0;
  logic       in_cout = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_s;
  logic [3:0] out_flags;
  logic [7:0] op_count;

  // Narrow-counter instance sharing all inputs, used to observe counter wrap.
  logic       in_ready2, out_valid2;
  logic [3:0] out_s2, out_flags2;
  logic [1:0] op_count2;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: queue of expected {s, flags}, accepted-push count.
  logic [7:0] mq[$];
  int         cnt = 0;
  logic [7:0] cur_exp;

  addsub_result_buffer #(.N(4), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_s(in_s), .in_cout(in_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s),
    .out_flags(out_flags), .op_count(op_count)
  );

  addsub_result_buffer #(.N(4), .CW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_s(in_s), .in_cout(in_cout),
    .out_valid(out_valid2), .out_ready(out_ready), .out_s(out_s2),
    .out_flags(out_flags2), .op_count(op_count2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Drive one upstream result; S/cout and expected flags come from plain
  // integer arithmetic and the signed range of a 4-bit value.
  task automatic drive(input int ua, input int ub, input bit sub, input bit vld);
    int full, s, sa, sb, sr;
    bit cout, v;
    if (sub) full = ua - ub + 16;
    else     full = ua + ub;
    s    = full % 16;
    cout = (full >= 16);
    sa   = (ua >= 8) ? ua - 16 : ua;
    sb   = (ub >= 8) ? ub - 16 : ub;
    sr   = sub ? sa - sb : sa + sb;
    v    = (sr > 7) || (sr < -8);
    in_a     = 4'(ua);
    in_b     = 4'(ub);
    in_sel   = sub;
    in_s     = 4'(s);
    in_cout  = cout;
    in_valid = vld;
    cur_exp  = {4'(s), (s >= 8), (s == 0), cout, v};
  endtask

  task automatic check_outputs();
    check("in_ready", 32'(in_ready), 32'(mq.size() < 2));
    check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    check("op_count", 32'(op_count), 32'(cnt % 256));
    check("op_count_cw2", 32'(op_count2), 32'(cnt % 4));
    if (mq.size() > 0) begin
      check("out_s", 32'(out_s), 32'(mq[0][7:4]));
      check("out_flags", 32'(out_flags), 32'(mq[0][3:0]));
    end
  endtask

  // One clock: the model applies the handshake seen at the edge, outputs
  // are compared at the following falling edge.
  task automatic step();
    bit push, pop;
    push = in_valid && (mq.size() < 2);
    pop  = out_ready && (mq.size() > 0);
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (push) begin
      mq.push_back(cur_exp);
      cnt++;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    mq.delete();
    cnt   = 0;
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    int k;
    // Reset state.
    @(negedge clk);
    do_reset();
    check("rst_out_s", 32'(out_s), 32'h0);
    check("rst_out_flags", 32'(out_flags), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);

    // 7+1: negative result with signed overflow.
    out_ready = 1'b1;
    drive(7, 1, 1'b0, 1'b1);
    step();
    check("add71_s", 32'(out_s), 32'h8);
    check("add71_flags", 32'(out_flags), 32'h9);
    check("add71_cnt", 32'(op_count), 32'd1);
    // 5-5 pushed while 7+1 pops: zero with carry set.
    drive(5, 5, 1'b1, 1'b1);
    step();
    check("sub55_s", 32'(out_s), 32'h0);
    check("sub55_flags", 32'(out_flags), 32'h6);
    in_valid = 1'b0;
    step();

    // Backpressure: 3, 4 fill the buffer, 9 waits upstream.
    do_reset();
    drive(3, 0, 1'b0, 1'b1); step();
    drive(4, 0, 1'b0, 1'b1); step();
    check("bp_full_in_ready", 32'(in_ready), 32'h0);
    drive(9, 0, 1'b0, 1'b1); step();
    check("bp_held_in_ready", 32'(in_ready), 32'h0);
    check("bp_head3", 32'(out_s), 32'h3);
    out_ready = 1'b1;
    k = 0;
    while (cnt < 3 && k < 10) begin
      step();
      k++;
    end
    check("bp_9_accepted", 32'(cnt >= 3), 32'h1);
    in_valid = 1'b0;
    while (mq.size() > 0 && k < 20) begin
      step();
      k++;
    end
    check("bp_drained", 32'(out_valid), 32'h0);
    check("bp_op_count", 32'(op_count), 32'd3);

    // Streaming 1..6 with simultaneous push/pop: one result per cycle.
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      drive(i, 0, 1'b0, 1'b1);
      step();
      check("stream_s", 32'(out_s), 32'(i));
      check("stream_vld", 32'(out_valid), 32'h1);
    end
    in_valid = 1'b0;
    step();
    check("stream_end", 32'(out_valid), 32'h0);

    // Asynchronous reset while full.
    do_reset();
    drive(2, 3, 1'b0, 1'b1); step();
    drive(6, 1, 1'b1, 1'b1); step();
    check("pre_rst_full", 32'(in_ready), 32'h0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'h0);
    check("arst_op_count", 32'(op_count), 32'h0);
    check("arst_in_ready", 32'(in_ready), 32'h1);
    check("arst_out_s", 32'(out_s), 32'h0);
    mq.delete();
    cnt = 0;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(int'($urandom_range(15)), int'($urandom_range(15)),
            bit'($urandom_range(1)), bit'($urandom_range(99) < 60));
      out_ready = ($urandom_range(99) < 55);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
